// File: rtl/record_packer_if.sv
// Record type and the word-in / record-out handshake bundle for record_packer.
// The package sits here so the bundle and the design share one record_t.
package record_packer_pkg;
    localparam int unsigned WORD_W = 32;

    typedef struct packed {
        logic signed [WORD_W-1:0] x;
        logic        [WORD_W-1:0] y;
    } record_t;
endpackage

interface record_packer_if #(
    parameter int unsigned COUNT_WIDTH = 16
);
    import record_packer_pkg::*;

    logic [WORD_W-1:0]      a_in;
    logic                   a_in_sync;
    logic                   a_in_notify;
    record_t                a_out;
    logic                   a_out_sync;
    logic                   a_out_notify;
    logic [COUNT_WIDTH-1:0] rec_count;

    // master drives the word source and the consumer ready; slave is the packer
    modport master (
        output a_in, a_in_sync, a_out_sync,
        input  a_in_notify, a_out, a_out_notify, rec_count
    );

    modport slave (
        input  a_in, a_in_sync, a_out_sync,
        output a_in_notify, a_out, a_out_notify, rec_count
    );
endinterface

// File: rtl/record_packer.sv
// Packs two consecutive 32-bit words into one record_t and hands it to the
// consumer over a notify/sync handshake; counts delivered records with wrap.
module record_packer
    import record_packer_pkg::*;
#(
    parameter bit          SWAP_ORDER  = 1'b0,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    record_packer_if.slave  bus
);

    typedef enum logic [1:0] {
        GET_FIRST  = 2'd0,
        GET_SECOND = 2'd1,
        SEND       = 2'd2
    } state_t;

    state_t                 state,      state_nxt;
    record_t                rec,        rec_nxt;
    logic                   in_notify,  in_notify_nxt;
    logic                   out_notify, out_notify_nxt;
    logic [COUNT_WIDTH-1:0] count,      count_nxt;

    // state and every output are flops; reset discards any partial/unsent record
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= GET_FIRST;
            rec        <= '0;
            in_notify  <= 1'b1;
            out_notify <= 1'b0;
            count      <= '0;
        end else begin
            state      <= state_nxt;
            rec        <= rec_nxt;
            in_notify  <= in_notify_nxt;
            out_notify <= out_notify_nxt;
            count      <= count_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        rec_nxt        = rec;
        in_notify_nxt  = in_notify;
        out_notify_nxt = out_notify;
        count_nxt      = count;

        case (state)
            GET_FIRST: begin
                if (bus.a_in_sync) begin
                    if (SWAP_ORDER) rec_nxt.y = bus.a_in;
                    else            rec_nxt.x = $signed(bus.a_in);
                    state_nxt = GET_SECOND;
                end
            end
            GET_SECOND: begin
                if (bus.a_in_sync) begin
                    if (SWAP_ORDER) rec_nxt.x = $signed(bus.a_in);
                    else            rec_nxt.y = bus.a_in;
                    in_notify_nxt  = 1'b0;
                    out_notify_nxt = 1'b1;
                    state_nxt      = SEND;
                end
            end
            SEND: begin
                // a_in_sync is ignored here: the source keeps holding its word
                if (bus.a_out_sync) begin
                    in_notify_nxt  = 1'b1;
                    out_notify_nxt = 1'b0;
                    count_nxt      = count + COUNT_WIDTH'(1);
                    state_nxt      = GET_FIRST;
                end
            end
            default: begin
                state_nxt      = GET_FIRST;
                in_notify_nxt  = 1'b1;
                out_notify_nxt = 1'b0;
            end
        endcase
    end

    assign bus.a_in_notify  = in_notify;
    assign bus.a_out_notify = out_notify;
    assign bus.a_out        = rec;
    assign bus.rec_count    = count;

endmodule

// File: tb/tb_record_packer.sv
// Directed bench: two packers (natural order / 16-bit count, swapped order /
// 2-bit count) driven in lockstep from one vector table plus reset sequences.
module tb_record_packer;
    import record_packer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    record_packer_if #(.COUNT_WIDTH(16)) ifc0 ();
    record_packer_if #(.COUNT_WIDTH(2))  ifc1 ();

    record_packer #(.SWAP_ORDER(1'b0), .COUNT_WIDTH(16)) u0 (
        .clk (clk), .rst (rst), .bus (ifc0.slave)
    );
    record_packer #(.SWAP_ORDER(1'b1), .COUNT_WIDTH(2)) u1 (
        .clk (clk), .rst (rst), .bus (ifc1.slave)
    );

    // inputs applied before an edge, expected natural-order outputs after it
    typedef struct {
        logic        is;
        logic [31:0] din;
        logic        os;
        logic        e_in_n;
        logic        e_out_n;
        logic [31:0] ex;
        logic [31:0] ey;
        int unsigned ecnt;
    } vec_t;

    vec_t vq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic add(input logic is, input logic [31:0] din, input logic os,
                       input logic e_in_n, input logic e_out_n,
                       input logic [31:0] ex, input logic [31:0] ey,
                       input int unsigned ecnt);
        vec_t v;
        v.is = is; v.din = din; v.os = os;
        v.e_in_n = e_in_n; v.e_out_n = e_out_n;
        v.ex = ex; v.ey = ey; v.ecnt = ecnt;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic is, input logic [31:0] din, input logic os);
        ifc0.a_in_sync = is; ifc0.a_in = din; ifc0.a_out_sync = os;
        ifc1.a_in_sync = is; ifc1.a_in = din; ifc1.a_out_sync = os;
    endtask

    task automatic step(input logic is, input logic [31:0] din, input logic os);
        @(negedge clk);
        drive(is, din, os);
        @(posedge clk);
        #1;
    endtask

    // checks both packers; the swapped one must hold the same fields exchanged
    task automatic chk_all(input string tag, input logic e_in_n, input logic e_out_n,
                           input logic [31:0] ex, input logic [31:0] ey,
                           input int unsigned ecnt);
        chk({tag, " u0.in_notify"},  32'(ifc0.a_in_notify),  32'(e_in_n));
        chk({tag, " u0.out_notify"}, 32'(ifc0.a_out_notify), 32'(e_out_n));
        chk({tag, " u0.x"},          32'(ifc0.a_out.x),      ex);
        chk({tag, " u0.y"},          ifc0.a_out.y,           ey);
        chk({tag, " u0.count"},      32'(ifc0.rec_count),    ecnt & 32'hFFFF);
        chk({tag, " u1.out_notify"}, 32'(ifc1.a_out_notify), 32'(e_out_n));
        chk({tag, " u1.x"},          32'(ifc1.a_out.x),      ey);
        chk({tag, " u1.y"},          ifc1.a_out.y,           ex);
        chk({tag, " u1.count"},      32'(ifc1.rec_count),    ecnt % 4);
    endtask

    initial begin
        drive(1'b0, 32'h0, 1'b0);

        // basic packing, both partners ready; the SEND-cycle word is ignored
        add(1, 32'h0000_0005, 1,   1, 0, 32'h5, 32'h0, 0);
        add(1, 32'hFFFF_FFFF, 1,   0, 1, 32'h5, 32'hFFFF_FFFF, 0);
        add(1, 32'h0000_0077, 1,   1, 0, 32'h5, 32'hFFFF_FFFF, 1);
        // second record, then consumer backpressure for 5 cycles
        add(1, 32'h1111_1111, 1,   1, 0, 32'h1111_1111, 32'hFFFF_FFFF, 1);
        add(1, 32'h8000_0000, 0,   0, 1, 32'h1111_1111, 32'h8000_0000, 1);
        for (int i = 0; i < 5; i++)
            add(1, 32'h0000_CAFE, 0, 0, 1, 32'h1111_1111, 32'h8000_0000, 1);
        add(1, 32'h0000_CAFE, 1,   1, 0, 32'h1111_1111, 32'h8000_0000, 2);
        // held word is now taken as the first field
        add(1, 32'h0000_CAFE, 0,   1, 0, 32'h0000_CAFE, 32'h8000_0000, 2);
        // source stall for 10 cycles in GET_SECOND
        for (int i = 0; i < 10; i++)
            add(0, 32'h0000_DEAD, 1, 1, 0, 32'h0000_CAFE, 32'h8000_0000, 2);
        add(1, 32'h0000_BEEF, 1,   0, 1, 32'h0000_CAFE, 32'h0000_BEEF, 2);
        add(0, 32'h0000_0000, 1,   1, 0, 32'h0000_CAFE, 32'h0000_BEEF, 3);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 1, 0, 32'h0, 32'h0, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].is, vq[i].din, vq[i].os);
            chk_all($sformatf("vec%0d", i), vq[i].e_in_n, vq[i].e_out_n,
                    vq[i].ex, vq[i].ey, vq[i].ecnt);
            if (i == 4) chk("u1.x negative", 32'($signed(ifc1.a_out.x) < 0), 32'd1);
        end

        // asynchronous reset while a partial record is held
        step(1, 32'h0000_1234, 0);
        chk_all("partial", 1, 0, 32'h1234, 32'h0000_BEEF, 3);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        #1;
        chk_all("rst_get2", 1, 0, 32'h0, 32'h0, 0);
        @(negedge clk);
        rst = 1'b0;
        step(1, 32'h0000_000A, 0);
        step(1, 32'h0000_000B, 0);
        chk_all("after_rst", 0, 1, 32'hA, 32'hB, 0);

        // reset in SEND with the consumer ready on the same cycle: no transfer
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1);
        rst = 1'b1;
        #1;
        chk_all("rst_send", 1, 0, 32'h0, 32'h0, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0);

        // five records: the 2-bit counter wraps 1,2,3,0,1
        for (int r = 0; r < 5; r++) begin
            step(1, 32'h100 + 32'(r), 1);
            step(1, 32'h200 + 32'(r), 1);
            chk_all($sformatf("wrap%0d_ready", r), 0, 1, 32'h100 + 32'(r),
                    32'h200 + 32'(r), 32'(r));
            step(0, 32'h0, 1);
            chk_all($sformatf("wrap%0d_done", r), 1, 0, 32'h100 + 32'(r),
                    32'h200 + 32'(r), 32'(r + 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
